// File: rtl/mem_arbiter_2p_if.sv
// Bundles the two requester ports, the shared memory port and the status outputs
// of the two-port memory arbiter.
interface mem_arbiter_2p_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic              m0_req;
    logic              m1_req;
    logic              m0_rw;
    logic              m1_rw;
    logic [ADDR_W-1:0] m0_addr;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [DATA_W-1:0] m1_wdata;
    logic              m0_done;
    logic              m1_done;
    logic              m0_err;
    logic              m1_err;
    logic [DATA_W-1:0] rdata;
    logic              mem_memrq;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    // The arbiter side.
    modport slave (
        input  m0_req, m1_req, m0_rw, m1_rw, m0_addr, m1_addr,
        input  m0_wdata, m1_wdata, mem_rdata,
        output m0_done, m1_done, m0_err, m1_err, rdata,
        output mem_memrq, mem_rw, mem_addr, mem_wdata, busy
    );

    // Requesters plus memory, as seen from outside the arbiter.
    modport master (
        output m0_req, m1_req, m0_rw, m1_rw, m0_addr, m1_addr,
        output m0_wdata, m1_wdata, mem_rdata,
        input  m0_done, m1_done, m0_err, m1_err, rdata,
        input  mem_memrq, mem_rw, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter_2p.sv
// Round-robin arbiter giving two requesters single-word access to one memory port.
// Each granted access runs IDLE -> ACCESS -> DONE, one cycle per state.
module mem_arbiter_2p #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_arbiter_2p_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;

    logic              owner_reg;
    logic              last_owner_reg;
    logic              rw_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;

    logic [1:0]        req_vec;
    logic [1:0]        rw_vec;
    logic [ADDR_W-1:0] addr_vec  [2];
    logic [DATA_W-1:0] wdata_vec [2];
    logic [1:0]        done_vec;
    logic [1:0]        err_vec;

    logic              grant_valid;
    logic              grant_idx;
    logic              oor;

    assign req_vec      = {bus.m1_req, bus.m0_req};
    assign rw_vec       = {bus.m1_rw, bus.m0_rw};
    assign addr_vec[0]  = bus.m0_addr;
    assign addr_vec[1]  = bus.m1_addr;
    assign wdata_vec[0] = bus.m0_wdata;
    assign wdata_vec[1] = bus.m1_wdata;

    // Any address bit at or above the implemented depth makes the access out of range.
    assign oor = |addr_reg[ADDR_W-1:DEPTH_LOG2];

    // On a tie the requester that did not own the previous access wins.
    always_comb begin
        grant_valid = |req_vec;
        grant_idx   = 1'b0;
        if (req_vec == 2'b11) begin
            grant_idx = ~last_owner_reg;
        end else if (req_vec[1]) begin
            grant_idx = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; requests are only looked at in IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = grant_valid ? ACCESS : IDLE;
            ACCESS:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Transfer latch and read-data capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_reg      <= 1'b0;
            last_owner_reg <= 1'b1;
            rw_reg         <= 1'b1;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            rdata_reg      <= '0;
        end else begin
            if (state_reg == IDLE && grant_valid) begin
                owner_reg      <= grant_idx;
                last_owner_reg <= grant_idx;
                rw_reg         <= rw_vec[grant_idx];
                addr_reg       <= addr_vec[grant_idx];
                wdata_reg      <= wdata_vec[grant_idx];
            end
            if (state_reg == ACCESS) begin
                if (oor) begin
                    rdata_reg <= '0;
                end else if (rw_reg) begin
                    rdata_reg <= bus.mem_rdata;
                end
            end
        end
    end

    // Memory port: parked as an idle read of address 0 except during an in-range ACCESS.
    always_comb begin
        bus.mem_memrq = 1'b0;
        bus.mem_rw    = 1'b1;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (state_reg == ACCESS && !oor) begin
            bus.mem_memrq = 1'b1;
            bus.mem_rw    = rw_reg;
            bus.mem_addr  = addr_reg;
            bus.mem_wdata = wdata_reg;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign done_vec[gi] = (state_reg == DONE) && (owner_reg == 1'(gi));
        assign err_vec[gi]  = done_vec[gi] && oor;
    end

    assign bus.m0_done = done_vec[0];
    assign bus.m1_done = done_vec[1];
    assign bus.m0_err  = err_vec[0];
    assign bus.m1_err  = err_vec[1];
    assign bus.rdata   = rdata_reg;
    assign bus.busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Randomised self-checking bench for mem_arbiter_2p: a 32-word memory model on the
// memory port and a transaction-level reference model of arbitration and data.
module tb_mem_arbiter_2p;

    localparam int AW = 12;
    localparam int DW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mem_arbiter_2p_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter_2p #(.ADDR_W(AW), .DATA_W(DW), .DEPTH_LOG2(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory attached to the arbiter.
    logic [DW-1:0] mem [32];
    always @(posedge clk) begin
        if (bus.mem_memrq && !bus.mem_rw) mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = (bus.mem_memrq && bus.mem_rw) ? mem[bus.mem_addr[4:0]] : 16'hDEAD;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state.
    logic [DW-1:0] ref_mem [32];
    int            ref_last;
    logic [DW-1:0] ref_rdata;
    int            done_cyc;
    int            done_owner;

    int total = 0;
    int bad   = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        ref_last  = 1;
        ref_rdata = '0;
    endtask

    // One three-cycle arbitration slot: drive requests, check ACCESS, check DONE.
    task automatic slot(input bit r0, input bit r1, input bit rw0, input bit rw1,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input bit hold, input bit late1, input bit scramble, input bit drop);
        int            w;
        bit            oor;
        bit            rw;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_rd;
        logic          exp_rw;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wd;

        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.mem_memrq !== 1'b0) begin
            bad++;
            $display("FAIL idle_state: busy=%0b memrq=%0b, expected 0 0", bus.busy, bus.mem_memrq);
        end
        bus.m0_req = r0;  bus.m0_rw = rw0;  bus.m0_addr = a0;  bus.m0_wdata = d0;
        bus.m1_req = r1;  bus.m1_rw = rw1;  bus.m1_addr = a1;  bus.m1_wdata = d1;

        if (r0 && r1)  w = (ref_last == 0) ? 1 : 0;
        else if (r1)   w = 1;
        else if (r0)   w = 0;
        else           w = -1;
        if (w >= 0) ref_last = w;
        a   = (w == 1) ? a1 : a0;
        d   = (w == 1) ? d1 : d0;
        rw  = (w == 1) ? rw1 : rw0;
        oor = (a[AW-1:5] != 0);
        exp_rw   = oor ? 1'b1 : rw;
        exp_addr = oor ? '0 : a;
        exp_wd   = oor ? '0 : d;

        @(negedge clk);
        total++;
        if (bus.busy !== (w >= 0) || bus.mem_memrq !== (w >= 0 && !oor)) begin
            bad++;
            $display("FAIL access_ctl: busy=%0b memrq=%0b, expected %0b %0b",
                     bus.busy, bus.mem_memrq, (w >= 0), (w >= 0 && !oor));
        end
        if (w >= 0) begin
            total++;
            if ({bus.mem_rw, bus.mem_addr, bus.mem_wdata} !== {exp_rw, exp_addr, exp_wd}) begin
                bad++;
                $display("FAIL access_bus: rw=%0b addr=%h wdata=%h, expected %0b %h %h",
                         bus.mem_rw, bus.mem_addr, bus.mem_wdata, exp_rw, exp_addr, exp_wd);
            end
            if (scramble) begin
                bus.m0_addr = AW'($urandom);  bus.m0_wdata = DW'($urandom);  bus.m0_rw = 1'($urandom);
                bus.m1_addr = AW'($urandom);  bus.m1_wdata = DW'($urandom);  bus.m1_rw = 1'($urandom);
            end
            if (drop) begin
                if (w == 1) bus.m1_req = 1'b0;
                else        bus.m0_req = 1'b0;
            end
        end
        if (late1) begin
            bus.m1_req = 1'b1;
            bus.m1_addr = a1; bus.m1_wdata = d1; bus.m1_rw = rw1;
        end
        #1;
        if (w >= 0) begin
            total++;
            if ({bus.mem_rw, bus.mem_addr, bus.mem_wdata} !== {exp_rw, exp_addr, exp_wd}) begin
                bad++;
                $display("FAIL access_hold: rw=%0b addr=%h wdata=%h, expected %0b %h %h",
                         bus.mem_rw, bus.mem_addr, bus.mem_wdata, exp_rw, exp_addr, exp_wd);
            end
        end

        @(negedge clk);
        exp_rd = ref_rdata;
        if (w >= 0) begin
            if (oor)     exp_rd = '0;
            else if (rw) exp_rd = ref_mem[a[4:0]];
            else         ref_mem[a[4:0]] = d;
            ref_rdata = exp_rd;
        end
        if (bus.m0_done || bus.m1_done) begin
            done_cyc   = cyc;
            done_owner = bus.m1_done ? 1 : 0;
        end
        total++;
        if (bus.m0_done !== (w == 0) || bus.m1_done !== (w == 1)) begin
            bad++;
            $display("FAIL done: m0_done=%0b m1_done=%0b, expected %0b %0b",
                     bus.m0_done, bus.m1_done, (w == 0), (w == 1));
        end
        if (w >= 0) begin
            total++;
            if (bus.m0_err !== (w == 0 && oor) || bus.m1_err !== (w == 1 && oor)) begin
                bad++;
                $display("FAIL err: m0_err=%0b m1_err=%0b, expected %0b %0b",
                         bus.m0_err, bus.m1_err, (w == 0 && oor), (w == 1 && oor));
            end
            total++;
            if (bus.rdata !== exp_rd) begin
                bad++;
                $display("FAIL rdata: got %h, expected %h (owner m%0d addr %h)", bus.rdata, exp_rd, w, a);
            end
        end
        $display("slot cyc=%0d req=%0b%0b owner=%0d rw=%0b addr=%h oor=%0b rdata=%h",
                 cyc, r1, r0, w, rw, a, oor, bus.rdata);
        if (!hold) begin
            bus.m0_req = 1'b0;
            bus.m1_req = late1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.m0_req = 1'b1; bus.m0_rw = 1'b0; bus.m0_addr = 12'h001; bus.m0_wdata = 16'hFFFF;
        bus.m1_req = 1'b1; bus.m1_rw = 1'b0; bus.m1_addr = 12'h002; bus.m1_wdata = 16'hFFFF;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.m0_done !== 1'b0 || bus.m1_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: busy=%0b done=%0b%0b, expected 0 00", bus.busy, bus.m1_done, bus.m0_done);
        end
        total++;
        if (bus.m0_err !== 1'b0 || bus.m1_err !== 1'b0 || bus.rdata !== 16'h0000) begin
            bad++;
            $display("FAIL reset_out: err=%0b%0b rdata=%h, expected 00 0000", bus.m1_err, bus.m0_err, bus.rdata);
        end
        total++;
        if ({bus.mem_memrq, bus.mem_rw, bus.mem_addr, bus.mem_wdata} !== {1'b0, 1'b1, 12'h000, 16'h0000}) begin
            bad++;
            $display("FAIL reset_mem: memrq=%0b rw=%0b addr=%h wdata=%h, expected 0 1 000 0000",
                     bus.mem_memrq, bus.mem_rw, bus.mem_addr, bus.mem_wdata);
        end
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
        rst_n      = 1'b1;
        ref_last   = 1;
        ref_rdata  = '0;
        $display("reset checked at cyc=%0d", cyc);
    endtask

    task automatic test_write_read();
        slot(1, 0, 0, 0, 12'h003, 12'h000, 16'hBEEF, 16'h0000, 0, 0, 0, 0);
        slot(1, 0, 1, 0, 12'h003, 12'h000, 16'h0000, 16'h0000, 0, 0, 0, 0);
        total++;
        if (bus.rdata !== 16'hBEEF) begin
            bad++;
            $display("FAIL write_read: rdata=%h, expected beef", bus.rdata);
        end
    endtask

    task automatic test_round_robin();
        int prev;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            prev = done_cyc;
            slot(1, 1, 1, 1, 12'h003, 12'h007, 16'h0, 16'h0, (i < 3), 0, 0, 0);
            total++;
            if (done_owner !== (i % 2)) begin
                bad++;
                $display("FAIL rr_owner: grant %0d went to m%0d, expected m%0d", i, done_owner, i % 2);
            end
            if (i > 0) begin
                total++;
                if (done_cyc - prev !== 3) begin
                    bad++;
                    $display("FAIL rr_spacing: done gap %0d cycles, expected 3", done_cyc - prev);
                end
            end
        end
    endtask

    task automatic test_out_of_range();
        slot(0, 1, 0, 1, 12'h000, 12'h020, 16'h0, 16'h0, 0, 0, 0, 0);
        total++;
        if (bus.rdata !== 16'h0000) begin
            bad++;
            $display("FAIL oor_rdata: rdata=%h, expected 0000", bus.rdata);
        end
    endtask

    task automatic test_late_arrival();
        slot(1, 0, 0, 0, 12'h009, 12'h00A, 16'h5A5A, 16'h1111, 0, 1, 0, 0);
        slot(0, 1, 0, 0, 12'h009, 12'h00A, 16'h0, 16'h1111, 0, 0, 0, 0);
        slot(1, 0, 1, 0, 12'h009, 12'h000, 16'h0, 16'h0, 0, 0, 0, 0);
        slot(0, 1, 0, 1, 12'h000, 12'h00A, 16'h0, 16'h0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_in_access();
        @(negedge clk);
        bus.m0_req = 1'b1; bus.m0_rw = 1'b0; bus.m0_addr = 12'h005; bus.m0_wdata = 16'h1234;
        bus.m1_req = 1'b0;
        @(negedge clk);
        total++;
        if (bus.mem_memrq !== 1'b1) begin
            bad++;
            $display("FAIL rst_access_memrq: memrq=%0b, expected 1", bus.mem_memrq);
        end
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.m0_done !== 1'b0 || bus.m1_done !== 1'b0) begin
            bad++;
            $display("FAIL rst_access_abort: busy=%0b done=%0b%0b, expected 0 00", bus.busy, bus.m1_done, bus.m0_done);
        end
        rst_n = 1'b1;
        bus.m0_req = 1'b0;
        ref_mem[5] = 16'h1234;
        ref_last   = 1;
        ref_rdata  = '0;
        $display("reset during access at cyc=%0d", cyc);
        slot(1, 0, 1, 0, 12'h005, 12'h000, 16'h0, 16'h0, 0, 0, 0, 0);
    endtask

    task automatic test_scramble_drop();
        slot(1, 0, 0, 0, 12'h00C, 12'h000, 16'hC0DE, 16'h0, 0, 0, 1, 1);
        slot(0, 1, 0, 0, 12'h000, 12'h00D, 16'h0, 16'h7E57, 0, 0, 1, 1);
        slot(1, 1, 1, 1, 12'h00C, 12'h00D, 16'h0, 16'h0, 0, 0, 0, 0);
        slot(1, 1, 1, 1, 12'h00C, 12'h00D, 16'h0, 16'h0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [AW-1:0] a0, a1;
        for (int i = 0; i < 40; i++) begin
            a0 = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(32, 4095)) : AW'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(32, 4095)) : AW'($urandom_range(0, 31));
            slot(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), a0, a1,
                 DW'($urandom), DW'($urandom), 0, 0, 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        bus.m0_req = 1'b0; bus.m0_rw = 1'b1; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 1'b0; bus.m1_rw = 1'b1; bus.m1_addr = '0; bus.m1_wdata = '0;
        ref_last   = 1;
        ref_rdata  = '0;
        done_cyc   = 0;
        done_owner = 0;

        test_reset();
        test_write_read();
        test_round_robin();
        test_out_of_range();
        test_late_arrival();
        test_reset_in_access();
        test_scramble_drop();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
